stereo_channel_scheduler: RTL and testbench

Time-shares one mono audio processing unit (the echo core) between the left and right channels of a stereo stream. Accepts a parallel stereo pair, issues left then right to the shared processor over a tagged valid/ready channel, and collects the two tagged results. Re-emits the processed pair as parallel left/right. Sits between the input parallelizer stage and the output serializer stage.

---
 rtl/audio_sched_pkg.sv | 17 +
 rtl/sched_timeout_counter.sv | 48 ++++
 rtl/stereo_channel_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_stereo_channel_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_sched_pkg.sv
// Shared definitions for the stereo channel scheduler.
//   - sched_state_e : scheduler FSM states
//   - AUDIO_WIDTH_DEFAULT / TIMEOUT_DEFAULT : default parameter values
package audio_sched_pkg;

    localparam int AUDIO_WIDTH_DEFAULT = 32'sd32;
    localparam int TIMEOUT_DEFAULT     = 32'sd1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_L = 3'd1,
        ISSUE_R = 3'd2,
        WAIT    = 3'd3,
        OUTPUT  = 3'd4
    } sched_state_e;

endpackage

// File: rtl/sched_timeout_counter.sv
// Cycle counter used to bound the wait for processor results.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   en         : count this cycle
//   clr        : force count to zero (wins over en)
//   terminal   : count has reached limit-1; never asserted when limit == 0
module sched_timeout_counter #(
    parameter int limit = 32'sd1024
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic terminal
);

    localparam int cnt_w = (limit > 32'sd1) ? $clog2(limit) : 32'sd1;
    localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(32'd1);
    localparam logic [cnt_w-1:0] cnt_last = (limit > 32'sd0) ? cnt_w'(limit - 32'sd1) : {cnt_w{1'b0}};
    localparam logic             enabled  = (limit != 32'sd0) ? 1'b1 : 1'b0;

    logic [cnt_w-1:0] cnt_q;
    logic [cnt_w-1:0] cnt_d;

    // Next count: clear has priority, otherwise advance when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {cnt_w{1'b0}};
        end else if (en) begin
            cnt_d = cnt_q + cnt_one;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {cnt_w{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign terminal = enabled & (cnt_q == cnt_last);

endmodule

// File: rtl/stereo_channel_scheduler.sv
// Time-shares one mono processor between the left and right channels.
// A stereo pair is accepted, left then right are issued over a tagged
// valid/ready channel, the two results are collected into o_left/o_right,
// and the processed pair is presented on a valid/ready output.
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   i_valid/i_ready/i_left/i_right      : input stereo pair
//   p_valid/p_ready/p_is_left/p_audio   : issue channel to the processor
//   r_valid/r_ready/r_is_left/r_audio   : result channel (r_ready always 1)
//   o_valid/o_ready/o_left/o_right      : processed stereo pair
//   err_order                           : sticky, mis-tagged or unexpected result
//   err_timeout                         : sticky, a missing result was zero-filled
module stereo_channel_scheduler
    import audio_sched_pkg::*;
#(
    parameter int audio_width    = AUDIO_WIDTH_DEFAULT,
    parameter int timeout_cycles = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [audio_width-1:0] i_left,
    input  logic [audio_width-1:0] i_right,
    output logic                   p_valid,
    input  logic                   p_ready,
    output logic                   p_is_left,
    output logic [audio_width-1:0] p_audio,
    input  logic                   r_valid,
    output logic                   r_ready,
    input  logic                   r_is_left,
    input  logic [audio_width-1:0] r_audio,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [audio_width-1:0] o_left,
    output logic [audio_width-1:0] o_right,
    output logic                   err_order,
    output logic                   err_timeout
);

    sched_state_e           state_q, state_d;
    logic [1:0]             outstanding_q, outstanding_d;
    logic                   got_l_q, got_l_d;
    logic                   got_r_q, got_r_d;
    logic [audio_width-1:0] left_in_q, left_in_d;
    logic [audio_width-1:0] right_in_q, right_in_d;
    logic [audio_width-1:0] o_left_q, o_left_d;
    logic [audio_width-1:0] o_right_q, o_right_d;
    logic                   err_order_q, err_order_d;
    logic                   err_timeout_q, err_timeout_d;

    logic issue_hs_s;
    logic result_exp_s;
    logic timeout_hit_s;

    // The timer runs only in WAIT and is held at zero elsewhere, so it
    // always starts from zero on WAIT entry.
    sched_timeout_counter #(
        .limit (timeout_cycles)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .en       (state_q == WAIT),
        .clr      (state_q != WAIT),
        .terminal (timeout_hit_s)
    );

    assign i_ready     = (state_q == IDLE);
    assign p_valid     = (state_q == ISSUE_L) | (state_q == ISSUE_R);
    assign p_is_left   = (state_q == ISSUE_L);
    assign p_audio     = (state_q == ISSUE_R) ? right_in_q : left_in_q;
    assign o_valid     = (state_q == OUTPUT);
    assign r_ready     = 1'b1;
    assign o_left      = o_left_q;
    assign o_right     = o_right_q;
    assign err_order   = err_order_q;
    assign err_timeout = err_timeout_q;

    assign issue_hs_s   = p_valid & p_ready;
    // Registered count: a result in the same cycle as its own issue
    // handshake is deliberately treated as unexpected.
    assign result_exp_s = r_valid & (outstanding_q != 2'd0);

    // Next-state, result collection and timeout substitution.
    always_comb begin
        state_d       = state_q;
        got_l_d       = got_l_q;
        got_r_d       = got_r_q;
        left_in_d     = left_in_q;
        right_in_d    = right_in_q;
        o_left_d      = o_left_q;
        o_right_d     = o_right_q;
        err_order_d   = err_order_q;
        err_timeout_d = err_timeout_q;

        // Results fill slots in arrival order; the tag is only checked.
        if (result_exp_s) begin
            if (!got_l_q) begin
                o_left_d = r_audio;
                got_l_d  = 1'b1;
                if (!r_is_left) begin
                    err_order_d = 1'b1;
                end else begin
                    err_order_d = err_order_q;
                end
            end else begin
                o_right_d = r_audio;
                got_r_d   = 1'b1;
                if (r_is_left) begin
                    err_order_d = 1'b1;
                end else begin
                    err_order_d = err_order_q;
                end
            end
        end else if (r_valid) begin
            err_order_d = 1'b1;
        end else begin
            err_order_d = err_order_q;
        end

        outstanding_d = outstanding_q + (issue_hs_s ? 2'd1 : 2'd0) - (result_exp_s ? 2'd1 : 2'd0);

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    left_in_d  = i_left;
                    right_in_d = i_right;
                    got_l_d    = 1'b0;
                    got_r_d    = 1'b0;
                    state_d    = ISSUE_L;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE_L: begin
                if (p_ready) begin
                    state_d = ISSUE_R;
                end else begin
                    state_d = ISSUE_L;
                end
            end
            ISSUE_R: begin
                if (p_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = ISSUE_R;
                end
            end
            WAIT: begin
                if (got_l_d && got_r_d) begin
                    state_d = OUTPUT;
                end else if (timeout_hit_s) begin
                    // Zero-fill whatever is still missing; anything arriving
                    // later is counted as unexpected.
                    if (!got_l_d) begin
                        o_left_d = {audio_width{1'b0}};
                    end else begin
                        o_left_d = o_left_d;
                    end
                    if (!got_r_d) begin
                        o_right_d = {audio_width{1'b0}};
                    end else begin
                        o_right_d = o_right_d;
                    end
                    err_timeout_d = 1'b1;
                    outstanding_d = 2'd0;
                    state_d       = OUTPUT;
                end else begin
                    state_d = WAIT;
                end
            end
            OUTPUT: begin
                if (o_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUTPUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            outstanding_q <= 2'd0;
            got_l_q       <= 1'b0;
            got_r_q       <= 1'b0;
            left_in_q     <= {audio_width{1'b0}};
            right_in_q    <= {audio_width{1'b0}};
            o_left_q      <= {audio_width{1'b0}};
            o_right_q     <= {audio_width{1'b0}};
            err_order_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            got_l_q       <= got_l_d;
            got_r_q       <= got_r_d;
            left_in_q     <= left_in_d;
            right_in_q    <= right_in_d;
            o_left_q      <= o_left_d;
            o_right_q     <= o_right_d;
            err_order_q   <= err_order_d;
            err_timeout_q <= err_timeout_d;
        end
    end

endmodule

// File: tb/tb_stereo_channel_scheduler.sv
// Self-checking bench for stereo_channel_scheduler: directed scenarios plus
// randomized pairs, against a transaction-level processor/pair model.
module tb_stereo_channel_scheduler;

    localparam int AW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid, i_ready;
    logic [AW-1:0] i_left, i_right;
    logic          p_valid, p_ready, p_is_left;
    logic [AW-1:0] p_audio;
    logic          r_valid, r_ready, r_is_left;
    logic [AW-1:0] r_audio;
    logic          o_valid, o_ready;
    logic [AW-1:0] o_left, o_right;
    logic          err_order, err_timeout;

    int unsigned cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stereo_channel_scheduler #(.audio_width(AW), .timeout_cycles(TO)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready), .i_left(i_left), .i_right(i_right),
        .p_valid(p_valid), .p_ready(p_ready), .p_is_left(p_is_left), .p_audio(p_audio),
        .r_valid(r_valid), .r_ready(r_ready), .r_is_left(r_is_left), .r_audio(r_audio),
        .o_valid(o_valid), .o_ready(o_ready), .o_left(o_left), .o_right(o_right),
        .err_order(err_order), .err_timeout(err_timeout)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Processor model: requests come back in order, +1, after proc_delay cycles.
    typedef struct { logic tag; logic [AW-1:0] data; int unsigned due; } req_t;
    typedef struct { logic tag; logic [AW-1:0] data; } iss_t;
    req_t proc_q[$];
    iss_t iss_q[$];
    int unsigned proc_delay = 1;
    bit proc_swap = 1'b0, proc_hold_right = 1'b0, inj_req = 1'b0;
    bit pr_rand = 1'b0, pr_low = 1'b0;

    initial begin : processor
        req_t rq;
        iss_t it;
        r_valid = 1'b0; r_is_left = 1'b0; r_audio = '0; p_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            r_valid = 1'b0;
            p_ready = pr_low ? 1'b0 : (pr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            if (inj_req) begin
                r_valid = 1'b1; r_is_left = 1'b1; r_audio = 32'hDEAD_BEEF; inj_req = 1'b0;
            end else if (proc_q.size() > 0 && proc_q[0].due <= cyc
                         && !(proc_hold_right && !proc_q[0].tag)) begin
                rq = proc_q.pop_front();
                r_valid = 1'b1; r_is_left = rq.tag ^ proc_swap; r_audio = rq.data + 32'd1;
            end
            @(negedge clk);
            if (p_valid && p_ready) begin
                if (iss_q.size() == 0) begin
                    check_eq("issue_unexpected", 64'(iss_q.size()), 64'd1);
                end else begin
                    it = iss_q.pop_front();
                    check_eq("issue_tag", 64'(p_is_left), 64'(it.tag));
                    check_eq("issue_data", 64'(p_audio), 64'(it.data));
                end
                proc_q.push_back('{tag: p_is_left, data: p_audio, due: cyc + proc_delay});
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_pair(input logic [AW-1:0] l, input logic [AW-1:0] r, output int unsigned hs);
        bit ok = 1'b0;
        hs = 0;
        i_left = l; i_right = r; i_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (i_ready) begin
                ok = 1'b1; hs = cyc;
                iss_q.push_back('{tag: 1'b1, data: l});
                iss_q.push_back('{tag: 1'b0, data: r});
                break;
            end
            tick();
        end
        check_eq("send_handshake", 64'(ok), 64'd1);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic recv_pair(input logic [AW-1:0] el, input logic [AW-1:0] er, input int hold, input string tag);
        bit ok = 1'b0;
        o_ready = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (o_valid) begin ok = 1'b1; break; end
            tick();
        end
        check_eq({tag, "_ovalid"}, 64'(ok), 64'd1);
        check_eq({tag, "_left"}, 64'(o_left), 64'(el));
        check_eq({tag, "_right"}, 64'(o_right), 64'(er));
        tick();
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, 64'(o_valid), 64'd1);
            check_eq({tag, "_hold_left"}, 64'(o_left), 64'(el));
            check_eq({tag, "_hold_right"}, 64'(o_right), 64'(er));
            check_eq({tag, "_hold_iready"}, 64'(i_ready), 64'd0);
            tick();
        end
        o_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, "_hs_valid"}, 64'(o_valid), 64'd1);
        tick();
        o_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "_after_iready"}, 64'(i_ready), 64'd1);
        check_eq({tag, "_after_ovalid"}, 64'(o_valid), 64'd0);
        tick();
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        proc_q.delete(); iss_q.delete();
        proc_hold_right = 1'b0; proc_swap = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_eq({tag, "_iready"}, 64'(i_ready), 64'd1);
        check_eq({tag, "_pvalid"}, 64'(p_valid), 64'd0);
        check_eq({tag, "_ovalid"}, 64'(o_valid), 64'd0);
        check_eq({tag, "_oleft"}, 64'(o_left), 64'd0);
        check_eq({tag, "_oright"}, 64'(o_right), 64'd0);
        check_eq({tag, "_err_order"}, 64'(err_order), 64'd0);
        check_eq({tag, "_err_timeout"}, 64'(err_timeout), 64'd0);
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        int unsigned hs;
        logic [AW-1:0] l, r;
        reset = 1'b1; i_valid = 1'b0; i_left = '0; i_right = '0; o_ready = 1'b0;
        repeat (3) tick();
        do_reset("reset");
        check_eq("r_ready", 64'(r_ready), 64'd1);

        // Basic pair and latency.
        send_pair(32'h0000_1111, 32'h0000_2222, hs);
        while (cyc != hs + 3) @(negedge clk);
        check_eq("lat_c3_ovalid", 64'(o_valid), 64'd0);
        @(negedge clk);
        check_eq("lat_c4_ovalid", 64'(o_valid), 64'd1);
        check_eq("basic_err_order", 64'(err_order), 64'd0);
        check_eq("basic_err_timeout", 64'(err_timeout), 64'd0);
        tick();
        recv_pair(32'h0000_1112, 32'h0000_2223, 0, "basic");

        // Issue backpressure in ISSUE_L.
        pr_low = 1'b1;
        send_pair(32'hA5A5_0001, 32'h5A5A_0002, hs);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("bp_pvalid", 64'(p_valid), 64'd1);
            check_eq("bp_is_left", 64'(p_is_left), 64'd1);
            check_eq("bp_audio", 64'(p_audio), 64'hA5A5_0001);
            check_eq("bp_iready", 64'(i_ready), 64'd0);
            tick();
        end
        pr_low = 1'b0;
        recv_pair(32'hA5A5_0002, 32'h5A5A_0003, 0, "bp");

        // Output backpressure.
        send_pair(32'h1234_5678, 32'h8765_4321, hs);
        recv_pair(32'h1234_5679, 32'h8765_4322, 5, "obp");

        // Swapped tags: stored by arrival slot, err_order set.
        proc_swap = 1'b1;
        send_pair(32'h0000_0100, 32'h0000_0200, hs);
        recv_pair(32'h0000_0101, 32'h0000_0201, 0, "swap");
        proc_swap = 1'b0;
        check_eq("swap_err_order", 64'(err_order), 64'd1);
        // Result in IDLE is discarded.
        inj_req = 1'b1;
        tick();
        @(negedge clk);
        check_eq("inj_err_order", 64'(err_order), 64'd1);
        check_eq("inj_oleft", 64'(o_left), 64'h0000_0101);
        check_eq("inj_oright", 64'(o_right), 64'h0000_0201);
        check_eq("inj_iready", 64'(i_ready), 64'd1);
        tick();

        // Timeout with right result withheld.
        do_reset("rst_pre_to");
        proc_hold_right = 1'b1;
        send_pair(32'h0000_0AAA, 32'h0000_0BBB, hs);
        while (cyc != hs + 10) @(negedge clk);
        check_eq("to_c10_ovalid", 64'(o_valid), 64'd0);
        @(negedge clk);
        check_eq("to_c11_ovalid", 64'(o_valid), 64'd1);
        check_eq("to_oleft", 64'(o_left), 64'h0000_0AAB);
        check_eq("to_oright", 64'(o_right), 64'd0);
        check_eq("to_err_timeout", 64'(err_timeout), 64'd1);
        check_eq("to_err_order", 64'(err_order), 64'd0);
        tick();
        proc_hold_right = 1'b0;
        tick();
        @(negedge clk);
        check_eq("late_err_order", 64'(err_order), 64'd1);
        check_eq("late_oright", 64'(o_right), 64'd0);
        tick();
        recv_pair(32'h0000_0AAB, 32'h0000_0000, 0, "to");

        // Reset while waiting for results.
        do_reset("rst_pre_mid");
        proc_hold_right = 1'b1;
        send_pair(32'h0000_0C0C, 32'h0000_0D0D, hs);
        repeat (4) tick();
        do_reset("rst_mid");
        send_pair(32'h0000_0E0E, 32'h0000_0F0F, hs);
        recv_pair(32'h0000_0E0F, 32'h0000_0F10, 0, "post_rst");

        // Randomized pairs with random issue/output stalls and latency.
        pr_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            proc_delay = $urandom_range(1, 3);
            l = $urandom;
            r = $urandom;
            send_pair(l, r, hs);
            recv_pair(l + 32'd1, r + 32'd1, int'($urandom_range(0, 3)), "rand");
        end
        pr_rand = 1'b0;
        check_eq("rand_err_order", 64'(err_order), 64'd0);
        check_eq("rand_err_timeout", 64'(err_timeout), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
